// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side word packer.
// The state is derived from the lane count except while a flush is pending.
package fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        FLUSH = 2'd3
    } rd_state_t;

    function automatic rd_state_t lane_state(input int lane, input int wb);
        if (lane == 32'sd0) begin
            return IDLE;
        end else if (lane >= wb) begin
            return FULL;
        end else begin
            return FILL;
        end
    endfunction

endpackage

// File: rtl/valid_ready_reg.sv
// One-entry output register with a valid/ready handshake.
// A load always wins; otherwise data is held and valid drops on acceptance.
module valid_ready_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Output entry: load, release on acceptance, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fifo_word_reader.sv
// Pops bytes from a show-ahead FIFO, packs them into words and emits full words,
// or partial words with byte enables on flush or idle timeout.
module fifo_word_reader
    import fifo_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                         clkb,
    input  logic                         rst_clkb,
    input  logic                         fifo_empty,
    input  logic [7:0]                   fifo_dout,
    output logic                         fifo_rd,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [8*WORD_BYTES-1:0]      word_out,
    output logic [WORD_BYTES-1:0]        word_be,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [CNT_W-1:0]             words_sent
);

    localparam int LANE_W = $clog2(WORD_BYTES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [LANE_W-1:0] LANE_FULL = LANE_W'(WORD_BYTES);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

    rd_state_t                         r_state;
    logic [LANE_W-1:0]                 r_lane;
    logic [WORD_BYTES-1:0][BYTE_W-1:0] r_pack;
    logic [IDLE_W-1:0]                 r_idle_cnt;
    logic                              r_flush_ext;
    logic                              r_flush_done;
    logic [CNT_W-1:0]                  r_words_sent;

    logic                              w_flush_pend;
    logic                              w_out_free;
    logic                              w_emit_req;
    logic                              w_xfer;
    logic                              w_pop;
    logic                              w_timeout;
    logic                              w_flush_req;
    logic                              w_flush_now;
    logic                              w_flush_exit;
    logic [LANE_W-1:0]                 w_lane_nxt;
    logic [LANE_W-1:0]                 w_wr_lane;
    logic [BYTE_W*WORD_BYTES-1:0]      w_word;
    logic [WORD_BYTES-1:0]             w_be;

    assign w_flush_pend = (r_state == FLUSH);
    assign w_out_free   = !word_valid | word_ready;
    assign w_emit_req   = (r_lane == LANE_FULL) | (w_flush_pend & (r_lane != '0));
    assign w_xfer       = w_emit_req & w_out_free;
    assign w_pop        = !rst_clkb & !fifo_empty & !w_flush_pend & ((r_lane < LANE_FULL) | w_xfer);
    assign fifo_rd      = w_pop;
    assign w_timeout    = (r_idle_cnt == IDLE_MAX);
    assign w_flush_req  = !w_flush_pend & (flush | w_timeout);
    // Flush completes on this edge when nothing is left in the pack or output register.
    assign w_flush_now  = (r_lane == '0) & !w_pop & w_out_free;
    assign w_flush_exit = w_flush_pend & (r_lane == '0) & w_out_free;
    assign w_wr_lane    = w_xfer ? '0 : r_lane;

    // Next lane count: a transfer empties the pack register, a pop fills one lane.
    always_comb begin
        w_lane_nxt = r_lane;
        if (w_xfer) begin
            w_lane_nxt = w_pop ? LANE_W'(1) : '0;
        end else if (w_pop) begin
            w_lane_nxt = r_lane + LANE_W'(1);
        end else begin
            w_lane_nxt = r_lane;
        end
    end

    // Masked word and byte enables presented to the output register.
    always_comb begin
        w_word = '0;
        w_be   = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (LANE_W'(i) < r_lane) begin
                w_word[i*BYTE_W +: BYTE_W] = r_pack[i];
                w_be[i]                    = 1'b1;
            end else begin
                w_word[i*BYTE_W +: BYTE_W] = '0;
                w_be[i]                    = 1'b0;
            end
        end
    end

    // Pack register, lane counter, idle counter and flush state machine.
    always_ff @(posedge clkb or posedge rst_clkb) begin
        if (rst_clkb) begin
            r_state      <= IDLE;
            r_lane       <= '0;
            r_pack       <= '0;
            r_idle_cnt   <= '0;
            r_flush_ext  <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_lane <= w_lane_nxt;
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (w_pop && (w_wr_lane == LANE_W'(i))) begin
                    r_pack[i] <= fifo_dout;
                end
            end
            if (w_pop || w_flush_pend || w_flush_req || (w_lane_nxt == '0)) begin
                r_idle_cnt <= '0;
            end else if ((r_lane != LANE_FULL) && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end else begin
                r_idle_cnt <= r_idle_cnt;
            end
            r_flush_done <= 1'b0;
            case (r_state)
                FLUSH: begin
                    if (w_flush_exit) begin
                        r_state      <= IDLE;
                        r_flush_done <= r_flush_ext;
                    end else begin
                        r_state <= FLUSH;
                    end
                end
                default: begin
                    if (w_flush_req && w_flush_now) begin
                        r_state      <= IDLE;
                        r_flush_done <= flush;
                    end else if (w_flush_req) begin
                        r_state     <= FLUSH;
                        r_flush_ext <= flush;
                    end else begin
                        r_state <= lane_state(int'(w_lane_nxt), WORD_BYTES);
                    end
                end
            endcase
        end
    end

    // Accepted-word counter, wraps silently.
    always_ff @(posedge clkb or posedge rst_clkb) begin
        if (rst_clkb) begin
            r_words_sent <= '0;
        end else if (word_valid && word_ready) begin
            r_words_sent <= r_words_sent + CNT_W'(1);
        end else begin
            r_words_sent <= r_words_sent;
        end
    end

    valid_ready_reg #(
        .W (BYTE_W*WORD_BYTES + WORD_BYTES)
    ) u_out (
        .clk     (clkb),
        .rst     (rst_clkb),
        .i_load  (w_xfer),
        .i_data  ({w_be, w_word}),
        .i_ready (word_ready),
        .o_valid (word_valid),
        .o_data  ({word_be, word_out})
    );

    assign flush_done = r_flush_done;
    assign words_sent = r_words_sent;

endmodule
